// File: rtl/bloom_filter_pkg.sv
// Shared types and helpers for the Bloom filter search path.
// Holds byte width, window FSM states and window sizing helpers.
package bloom_filter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } win_state_t;

  function automatic int empty_w(input int syms);
    return (syms == 1) ? 1 : $clog2(syms);
  endfunction

  function automatic int vb_w(input int win);
    return $clog2(win + 1);
  endfunction

  // min(win, cnt+p+1)
  function automatic int sat_vb(
    input int cnt,
    input int p,
    input int win
  );
    int s;
    s = cnt + p + 1;
    return (s > win) ? win : s;
  endfunction

endpackage

// File: rtl/ast_window_gen_if.sv
// Avalon ST sink plus window output bundle for ast_window_gen.
// slave: DUT view (sink in, windows out); master: producer/consumer view.
interface ast_window_gen_if
  import bloom_filter_pkg::*;
#(
  parameter int AST_SINK_SYMBOLS = 8,
  parameter int WINDOW_SIZE      = 16
);

  localparam int EW  = empty_w(AST_SINK_SYMBOLS);
  localparam int VBW = vb_w(WINDOW_SIZE);
  localparam int DW  = AST_SINK_SYMBOLS * BYTE_W;
  localparam int WW  = AST_SINK_SYMBOLS * WINDOW_SIZE * BYTE_W;

  logic [DW-1:0]                   ast_sink_data;
  logic                            ast_sink_ready;
  logic                            ast_sink_valid;
  logic [EW-1:0]                   ast_sink_empty;
  logic                            ast_sink_endofpacket;
  logic                            ast_sink_startofpacket;
  logic [WW-1:0]                   windows_data;
  logic [AST_SINK_SYMBOLS*VBW-1:0] windows_valid_bytes;
  logic [AST_SINK_SYMBOLS-1:0]     windows_mask;
  logic                            windows_valid;
  logic                            windows_ready;
  logic                            windows_sop;
  logic                            windows_eop;

  modport slave (
    input  ast_sink_data,
    output ast_sink_ready,
    input  ast_sink_valid,
    input  ast_sink_empty,
    input  ast_sink_endofpacket,
    input  ast_sink_startofpacket,
    output windows_data,
    output windows_valid_bytes,
    output windows_mask,
    output windows_valid,
    input  windows_ready,
    output windows_sop,
    output windows_eop
  );

  modport master (
    output ast_sink_data,
    input  ast_sink_ready,
    output ast_sink_valid,
    output ast_sink_empty,
    output ast_sink_endofpacket,
    output ast_sink_startofpacket,
    input  windows_data,
    input  windows_valid_bytes,
    input  windows_mask,
    input  windows_valid,
    output windows_ready,
    input  windows_sop,
    input  windows_eop
  );

endinterface

// File: rtl/ast_window_slice.sv
// Combinational slicer: cuts SYMS windows out of {beat, history}.
// Ports: cat_i (stream-ordered bytes), cnt_i, eop_i, empty_i -> data_o, vb_o, mask_o.
module ast_window_slice
  import bloom_filter_pkg::*;
#(
  parameter  int SYMS = 8,
  parameter  int WIN  = 16,
  localparam int EW   = empty_w(SYMS),
  localparam int VBW  = vb_w(WIN),
  localparam int CATN = WIN - 1 + SYMS
) (
  input  logic [CATN*BYTE_W-1:0]     cat_i,
  input  logic [VBW-1:0]             cnt_i,
  input  logic                       eop_i,
  input  logic [EW-1:0]              empty_i,
  output logic [SYMS*WIN*BYTE_W-1:0] data_o,
  output logic [SYMS*VBW-1:0]        vb_o,
  output logic [SYMS-1:0]            mask_o
);

  logic real_p;
  int   lim;

  always_comb begin
    data_o = '0;
    vb_o   = '0;
    mask_o = '0;
    real_p = 1'b0;
    lim    = SYMS - int'(empty_i);
    for (int p = 0; p < SYMS; p++) begin
      // byte k of window p sits k positions before stream slot p
      for (int k = 0; k < WIN; k++) begin
        data_o[(p*WIN+k)*BYTE_W +: BYTE_W] =
          cat_i[(WIN-1+p-k)*BYTE_W +: BYTE_W];
      end
      real_p = !eop_i || (p < lim);
      mask_o[p] = real_p;
      vb_o[p*VBW +: VBW] = real_p
        ? VBW'(sat_vb(int'(cnt_i), p, WIN))
        : '0;
    end
  end

endmodule

// File: rtl/ast_window_gen.sv
// Sliding-window generator: Avalon ST bytes -> per-position windows, 1-cycle latency.
// Ports: clk_i, arst_n_i, en_i, bus (ast_window_gen_if.slave); proto_err_o with AST_WINDOW_GEN_PROTO_CHECK_EN.
module ast_window_gen
  import bloom_filter_pkg::*;
#(
  parameter int AST_SINK_SYMBOLS = 8,
  parameter int AST_SINK_ORDER   = 1,
  parameter int WINDOW_SIZE      = 16
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic en_i,
`ifdef AST_WINDOW_GEN_PROTO_CHECK_EN
  output logic proto_err_o,
`endif
  ast_window_gen_if.slave bus
);

  localparam int SYMS = AST_SINK_SYMBOLS;
  localparam int WIN  = WINDOW_SIZE;
  localparam int VBW  = vb_w(WIN);
  localparam int HN   = WIN - 1;
  localparam int CATN = HN + SYMS;
  localparam int WW   = SYMS * WIN * BYTE_W;

  win_state_t state_q, state_d;

  logic [HN*BYTE_W-1:0]   hist_q, hist_d, hist_eff;
  logic [VBW-1:0]         cnt_q, cnt_d, cnt_eff;
  logic [SYMS*BYTE_W-1:0] beat;
  logic [CATN*BYTE_W-1:0] cat;

  logic rdy, acc, load, sop, eop;
  int   sum;

  logic [WW-1:0]       s_data, data_q;
  logic [SYMS*VBW-1:0] s_vb, vb_q;
  logic [SYMS-1:0]     s_mask, mask_q;
  logic                vld_q, sop_q, eop_q;

  assign sop = bus.ast_sink_startofpacket;
  assign eop = bus.ast_sink_endofpacket;
  assign rdy = !vld_q || bus.windows_ready;
  assign acc = bus.ast_sink_valid && rdy;

  // position 0 = first symbol of the beat
  always_comb begin
    beat = '0;
    for (int p = 0; p < SYMS; p++) begin
      if (AST_SINK_ORDER != 0)
        beat[p*BYTE_W +: BYTE_W] =
          bus.ast_sink_data[(SYMS-1-p)*BYTE_W +: BYTE_W];
      else
        beat[p*BYTE_W +: BYTE_W] =
          bus.ast_sink_data[p*BYTE_W +: BYTE_W];
    end
  end

  // SOP starts from a clean slate regardless of leftovers
  assign hist_eff = sop ? '0 : hist_q;
  assign cnt_eff  = sop ? '0 : cnt_q;
  assign cat      = {beat, hist_eff};

  ast_window_slice #(
    .SYMS (SYMS),
    .WIN  (WIN)
  ) u_slice (
    .cat_i   (cat),
    .cnt_i   (cnt_eff),
    .eop_i   (eop),
    .empty_i (bus.ast_sink_empty),
    .data_o  (s_data),
    .vb_o    (s_vb),
    .mask_o  (s_mask)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      acc && sop:
        state_d = eop ? IDLE : (en_i ? PASS : DROP);
      acc && !sop && eop:
        state_d = IDLE;
      default: ;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    hist_d = hist_q;
    cnt_d  = cnt_q;
    sum    = 0;
    unique case (1'b1)
      acc && sop:  load = en_i;
      acc && !sop: load = (state_q == PASS);
      default: ;
    endcase
    if (load) begin
      hist_d = cat[SYMS*BYTE_W +: HN*BYTE_W];
      sum    = int'(cnt_eff) + SYMS;
      cnt_d  = (sum > WIN) ? VBW'(WIN) : VBW'(sum);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      data_q <= '0;
      vb_q   <= '0;
      mask_q <= '0;
    end else if (load) begin
      vld_q  <= 1'b1;
      sop_q  <= sop;
      eop_q  <= eop;
      data_q <= s_data;
      vb_q   <= s_vb;
      mask_q <= s_mask;
    end else if (bus.windows_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.ast_sink_ready      = rdy;
  assign bus.windows_valid       = vld_q;
  assign bus.windows_sop         = sop_q;
  assign bus.windows_eop         = eop_q;
  assign bus.windows_data        = data_q;
  assign bus.windows_valid_bytes = vb_q;
  assign bus.windows_mask        = mask_q;

`ifdef AST_WINDOW_GEN_PROTO_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = acc && (
      (state_q == IDLE && !sop) ||
      (state_q != IDLE && sop)  ||
      (!eop && bus.ast_sink_empty != '0));
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign proto_err_o = err_q;
`endif

endmodule

// File: tb/tb_ast_window_gen.sv
// Directed bench for ast_window_gen (4 symbols, 6-byte windows).
// Runs AST_SINK_ORDER=1 and =0 instances side by side on the same stream.
module tb_ast_window_gen;
  import bloom_filter_pkg::*;

  localparam int S  = 4;
  localparam int W  = 6;
  localparam int WW = S * W * 8;

  typedef struct {
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        en;
    logic [31:0] bytes;
    logic        xv;
    logic [3:0]  xmask;
    logic [11:0] xvb;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n;
  logic en;
  int   nerr, nchk;

  ast_window_gen_if #(.AST_SINK_SYMBOLS(S), .WINDOW_SIZE(W)) if1 ();
  ast_window_gen_if #(.AST_SINK_SYMBOLS(S), .WINDOW_SIZE(W)) if0 ();

`ifdef AST_WINDOW_GEN_PROTO_CHECK_EN
  logic perr [2];
`endif

  ast_window_gen #(
    .AST_SINK_SYMBOLS (S),
    .AST_SINK_ORDER   (1),
    .WINDOW_SIZE      (W)
  ) dut1 (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .en_i        (en),
`ifdef AST_WINDOW_GEN_PROTO_CHECK_EN
    .proto_err_o (perr[1]),
`endif
    .bus         (if1)
  );

  ast_window_gen #(
    .AST_SINK_SYMBOLS (S),
    .AST_SINK_ORDER   (0),
    .WINDOW_SIZE      (W)
  ) dut0 (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .en_i        (en),
`ifdef AST_WINDOW_GEN_PROTO_CHECK_EN
    .proto_err_o (perr[0]),
`endif
    .bus         (if0)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] wd [2];
  logic [11:0]   wvb [2];
  logic [3:0]    wm [2];
  logic          wv [2], ws [2], we [2], wr [2];

  assign wd[0]  = if0.windows_data;
  assign wd[1]  = if1.windows_data;
  assign wvb[0] = if0.windows_valid_bytes;
  assign wvb[1] = if1.windows_valid_bytes;
  assign wm[0]  = if0.windows_mask;
  assign wm[1]  = if1.windows_mask;
  assign wv[0]  = if0.windows_valid;
  assign wv[1]  = if1.windows_valid;
  assign ws[0]  = if0.windows_sop;
  assign ws[1]  = if1.windows_sop;
  assign we[0]  = if0.windows_eop;
  assign we[1]  = if1.windows_eop;
  assign wr[0]  = if0.ast_sink_ready;
  assign wr[1]  = if1.ast_sink_ready;

  // reference: bytes of the passing packet, oldest first
  logic [7:0]  mq [$];
  logic [7:0]  oh [$];
  logic [31:0] ob;

  function automatic logic [11:0] vb4(int a, int b, int c, int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic vec_t mk(logic s, logic e, logic [1:0] em,
                              logic n, logic [31:0] b, logic v,
                              logic [3:0] m, logic [11:0] vb);
    vec_t r;
    r.sop = s; r.eop = e; r.empty = em; r.en = n;
    r.bytes = b; r.xv = v; r.xmask = m; r.xvb = vb;
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(int p, int k);
    int n, pos;
    n = oh.size();
    pos = n + p - k;
    if (pos < 0) return 8'h00;
    if (pos < n) return oh[pos];
    return ob[(3-(pos-n))*8 +: 8];
  endfunction

  function automatic logic [47:0] exp_win(int p);
    logic [47:0] w;
    for (int k = 0; k < W; k++) w[k*8 +: 8] = exp_byte(p, k);
    return w;
  endfunction

  task automatic model_accept(input logic s, input logic [31:0] b);
    if (s) mq.delete();
    oh = mq;
    ob = b;
    for (int j = 0; j < 4; j++) mq.push_back(b[(3-j)*8 +: 8]);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic s,
                          input logic e, input logic [1:0] em,
                          input logic n, input logic [31:0] b);
    if1.ast_sink_valid = v;
    if0.ast_sink_valid = v;
    if1.ast_sink_startofpacket = s;
    if0.ast_sink_startofpacket = s;
    if1.ast_sink_endofpacket = e;
    if0.ast_sink_endofpacket = e;
    if1.ast_sink_empty = em;
    if0.ast_sink_empty = em;
    en = n;
    if1.ast_sink_data = b;
    if0.ast_sink_data = {b[7:0], b[15:8], b[23:16], b[31:24]};
  endtask

  task automatic set_rdy(input logic r);
    if1.windows_ready = r;
    if0.windows_ready = r;
  endtask

  task automatic chk_out(input string nm, input logic xv,
                         input logic xs, input logic xe,
                         input logic [3:0] xm, input logic [11:0] xvb);
    for (int d = 0; d < 2; d++) begin
      string t;
      t = $sformatf("%s/o%0d", nm, d);
      chk({t, "/valid"}, 64'(wv[d]), 64'(xv));
      if (xv) begin
        chk({t, "/sop"}, 64'(ws[d]), 64'(xs));
        chk({t, "/eop"}, 64'(we[d]), 64'(xe));
        chk({t, "/mask"}, 64'(wm[d]), 64'(xm));
        chk({t, "/vb"}, 64'(wvb[d]), 64'(xvb));
        for (int p = 0; p < S; p++)
          if (xm[p])
            chk($sformatf("%s/win%0d", t, p),
                64'(wd[d][p*48 +: 48]), 64'(exp_win(p)));
      end
    end
  endtask

  task automatic chk_rst(input string nm);
    for (int d = 0; d < 2; d++) begin
      string t;
      t = $sformatf("%s/o%0d", nm, d);
      chk({t, "/valid"}, 64'(wv[d]), 64'd0);
      chk({t, "/sop"}, 64'(ws[d]), 64'd0);
      chk({t, "/eop"}, 64'(we[d]), 64'd0);
      chk({t, "/mask"}, 64'(wm[d]), 64'd0);
      chk({t, "/vb"}, 64'(wvb[d]), 64'd0);
      chk({t, "/data0"}, 64'(wd[d] == '0), 64'd1);
      chk({t, "/ready"}, 64'(wr[d]), 64'd1);
    end
  endtask

  vec_t tv [15];

  initial begin
    nerr = 0;
    nchk = 0;
    arst_n = 1'b0;
    set_rdy(1'b1);
    set_beat(0, 0, 0, 0, 0, 32'h0);

    #12;
    chk_rst("reset");
    #5 arst_n = 1'b1;
    step();
    chk_rst("reset_rel");

    tv[0]  = mk(1, 1, 0, 1, "ABCD", 1, 4'hF, vb4(1, 2, 3, 4));
    tv[1]  = mk(1, 0, 0, 1, "ABCD", 1, 4'hF, vb4(1, 2, 3, 4));
    tv[2]  = mk(0, 0, 0, 1, "EFGH", 1, 4'hF, vb4(5, 6, 6, 6));
    tv[3]  = mk(0, 1, 2, 1, "IJKL", 1, 4'h3, vb4(6, 6, 0, 0));
    tv[4]  = mk(1, 0, 0, 0, "MNOP", 0, 4'h0, 12'h0);
    tv[5]  = mk(0, 0, 0, 1, "QRST", 0, 4'h0, 12'h0);
    tv[6]  = mk(0, 1, 0, 1, "UVWX", 0, 4'h0, 12'h0);
    tv[7]  = mk(1, 0, 0, 1, "abcd", 1, 4'hF, vb4(1, 2, 3, 4));
    tv[8]  = mk(1, 0, 0, 1, "efgh", 1, 4'hF, vb4(1, 2, 3, 4));
    tv[9]  = mk(0, 1, 3, 1, "ijkl", 1, 4'h1, vb4(5, 0, 0, 0));
    tv[10] = mk(0, 0, 0, 1, "mnop", 0, 4'h0, 12'h0);
    tv[11] = mk(1, 1, 1, 0, "qrst", 0, 4'h0, 12'h0);
    tv[12] = mk(1, 1, 1, 1, "uvwx", 1, 4'h7, vb4(1, 2, 3, 0));
    tv[13] = mk(1, 0, 3, 1, "ABCD", 1, 4'hF, vb4(1, 2, 3, 4));
    tv[14] = mk(0, 1, 0, 1, "EFGH", 1, 4'hF, vb4(5, 6, 6, 6));

    for (int i = 0; i < 15; i++) begin
      set_beat(1, tv[i].sop, tv[i].eop, tv[i].empty,
               tv[i].en, tv[i].bytes);
      step();
      if (tv[i].xv) model_accept(tv[i].sop, tv[i].bytes);
      chk_out($sformatf("vec%0d", i), tv[i].xv, tv[i].sop,
              tv[i].eop, tv[i].xmask, tv[i].xvb);
      if (i == 0) begin
        chk("vec0/w0b0", 64'(wd[1][7:0]), 64'("A"));
        chk("vec0/w3", 64'(wd[1][3*48 +: 48]), 64'("ABCD"));
      end
      if (i == 3)
        chk("vec3/w1", 64'(wd[1][1*48 +: 48]), 64'("EFGHIJ"));
    end
    set_beat(0, 0, 0, 0, 0, 32'h0);
    step();
    chk_out("idle", 0, 0, 0, 4'h0, 12'h0);

    // backpressure: output must hold, next beat must wait
    set_rdy(1'b0);
    set_beat(1, 1, 0, 0, 1, "ABCD");
    step();
    model_accept(1, "ABCD");
    set_beat(1, 0, 0, 0, 1, "EFGH");
    for (int c = 0; c < 3; c++) begin
      chk_out($sformatf("bp_hold%0d", c), 1, 1, 0, 4'hF,
              vb4(1, 2, 3, 4));
      chk($sformatf("bp_rdy%0d/o1", c), 64'(wr[1]), 64'd0);
      chk($sformatf("bp_rdy%0d/o0", c), 64'(wr[0]), 64'd0);
      step();
    end
    set_rdy(1'b1);
    #1;
    chk("bp_rdy_up", 64'(wr[1]), 64'd1);
    step();
    model_accept(0, "EFGH");
    chk_out("bp_b2", 1, 0, 0, 4'hF, vb4(5, 6, 6, 6));
    set_beat(1, 0, 1, 0, 1, "IJKL");
    step();
    model_accept(0, "IJKL");
    chk_out("bp_b3", 1, 0, 1, 4'hF, vb4(6, 6, 6, 6));
    set_beat(0, 0, 0, 0, 0, 32'h0);
    step();
    chk_out("bp_done", 0, 0, 0, 4'h0, 12'h0);

    // reset in the middle of a packet
    set_beat(1, 1, 0, 0, 1, "ABCD");
    step();
    model_accept(1, "ABCD");
    chk_out("mid_pre", 1, 1, 0, 4'hF, vb4(1, 2, 3, 4));
    set_beat(0, 0, 0, 0, 1, 32'h0);
    #3 arst_n = 1'b0;
    #1;
    chk_rst("mid_rst");
    #1 arst_n = 1'b1;
    set_beat(1, 0, 0, 0, 1, "EFGH");
    step();
    chk_out("mid_nosop", 0, 0, 0, 4'h0, 12'h0);
`ifdef AST_WINDOW_GEN_PROTO_CHECK_EN
    chk("mid_perr/o1", 64'(perr[1]), 64'd1);
    chk("mid_perr/o0", 64'(perr[0]), 64'd1);
`endif
    set_beat(0, 0, 0, 0, 0, 32'h0);
    step();
    chk_out("mid_after", 0, 0, 0, 4'h0, 12'h0);
`ifdef AST_WINDOW_GEN_PROTO_CHECK_EN
    chk("mid_perr_end/o1", 64'(perr[1]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
